axi_stream_gray_conv: RTL and testbench

AXI_STREAM_GRAY_CONV -- requirements
Module: axi_stream_gray_conv

---
 rtl/axi_stream_pkg.sv | 18 +
 rtl/axi_stream_pipe_stage.sv | 49 ++++
 rtl/axi_stream_gray_conv.sv | 183 ++++++++++++++++++
 tb/tb_axi_stream_gray_conv.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// Shared types for the AXI-Stream gray converter.
//   state_e : input framing FSM (header beats, then pixel beats)
//   mode_e  : output format selection, latched per frame
package axi_stream_pkg;

    typedef enum logic {
        HDR = 1'b0,
        PIX = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        MODE_GRAY_REP = 2'd0,   // gray copied into R, G and B
        MODE_GRAY_LO  = 2'd1,   // gray in R lane, G/B zero
        MODE_BYPASS   = 2'd2,   // pixel passed through untouched
        MODE_BYPASS_3 = 2'd3    // reserved code, behaves as bypass
    } mode_e;

endpackage

// File: rtl/axi_stream_pipe_stage.sv
// One register slice of a valid/ready pipeline.
//   in_valid_i/in_ready_o/in_data_i    : upstream handshake
//   out_valid_o/out_ready_i/out_data_o : downstream handshake (registered)
// The slice loads whenever it is empty or its content leaves this cycle,
// giving full throughput with a combinational ready path.
module axi_stream_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;
    logic         load;

    assign load = !valid_q || out_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = in_valid_i;
            // data only captured with a real beat so idle-bus noise never lands in state
            if (in_valid_i) data_d = in_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready_o  = load;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/axi_stream_gray_conv.sv
// RGB -> gray converter on an AXI-Stream video link.
// Each frame: HDR_WORDS header beats passed through bit-exact, then pixels
// until tlast. Pixels become round((R*cr + G*cg + B*cb) / 2^COEF_W),
// saturated, formatted per mode. Mode/coefficients latch on header beat 0.
//   clk_i, rst_i                       : clock, async active-high reset
//   mode_i, coef_{r,g,b}_i             : per-frame configuration
//   tvalid_i/tready_o/tlast_i/tdata_i  : slave stream
//   tvalid_o/tready_i/tlast_o/tdata_o  : master stream
//   frame_done_o                       : pulse after a tlast beat leaves
module axi_stream_gray_conv
    import axi_stream_pkg::*;
#(
    parameter int CW        = 8,
    parameter int HDR_WORDS = 2,
    parameter int COEF_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mode_i,
    input  logic [COEF_W-1:0] coef_r_i,
    input  logic [COEF_W-1:0] coef_g_i,
    input  logic [COEF_W-1:0] coef_b_i,
    input  logic              tvalid_i,
    output logic              tready_o,
    input  logic              tlast_i,
    input  logic [3*CW-1:0]   tdata_i,
    output logic              tvalid_o,
    input  logic              tready_i,
    output logic              tlast_o,
    output logic [3*CW-1:0]   tdata_o,
    output logic              frame_done_o
);

    localparam int PW    = CW + COEF_W;
    localparam int SW    = CW + COEF_W + 2;
    localparam int CNT_W = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
    localparam logic [SW-1:0]    RND      = SW'(1) << (COEF_W - 1);
    localparam logic [SW-1:0]    GRAY_MAX = SW'({CW{1'b1}});
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HDR_WORDS - 1);

    typedef struct packed {
        logic            hdr;
        logic            last;
        mode_e           mode;
        logic [3*CW-1:0] data;
        logic [PW-1:0]   pr;
        logic [PW-1:0]   pg;
        logic [PW-1:0]   pb;
    } s1_t;

    typedef struct packed {
        logic            last;
        logic [3*CW-1:0] data;
    } s2_t;

    // ---------------- framing FSM and per-frame config ----------------
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    mode_e             mode_q,  mode_d;
    logic [COEF_W-1:0] cr_q, cr_d, cg_q, cg_d, cb_q, cb_d;
    logic              frame_done_q, frame_done_d;
    logic              s1_in_ready, acc;

    assign tready_o = s1_in_ready && !rst_i;
    assign acc      = tvalid_i && tready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        cr_d    = cr_q;
        cg_d    = cg_q;
        cb_d    = cb_q;
        if (acc) begin
            if (state_q == HDR) begin
                if (cnt_q == '0) begin
                    mode_d = mode_e'(mode_i);
                    cr_d   = coef_r_i;
                    cg_d   = coef_g_i;
                    cb_d   = coef_b_i;
                end
                if (tlast_i) begin
                    // short frame: abandon it and expect a fresh header
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (tlast_i) begin
                state_d = HDR;
            end
        end
    end

    // ---------------- stage 1: products ----------------
    s1_t s1_in, s1_out;
    logic s1_out_valid, s2_in_ready;

    always_comb begin
        s1_in      = '0;
        // a header beat uses the mode being latched this cycle only
        // nominally; headers bypass arithmetic anyway
        s1_in.hdr  = (state_q == HDR);
        s1_in.last = tlast_i;
        s1_in.mode = mode_q;
        s1_in.data = tdata_i;
        s1_in.pr   = PW'(tdata_i[CW-1:0])      * PW'(cr_q);
        s1_in.pg   = PW'(tdata_i[2*CW-1:CW])   * PW'(cg_q);
        s1_in.pb   = PW'(tdata_i[3*CW-1:2*CW]) * PW'(cb_q);
    end

    axi_stream_pipe_stage #(.W($bits(s1_t))) u_s1 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (tvalid_i),
        .in_ready_o  (s1_in_ready),
        .in_data_i   (s1_in),
        .out_valid_o (s1_out_valid),
        .out_ready_i (s2_in_ready),
        .out_data_o  (s1_out)
    );

    // ---------------- stage 2: round, saturate, format ----------------
    s2_t           s2_in, s2_out;
    logic [SW-1:0] sum, scaled;
    logic [CW-1:0] gray;

    always_comb begin
        sum    = SW'(s1_out.pr) + SW'(s1_out.pg) + SW'(s1_out.pb) + RND;
        scaled = sum >> COEF_W;
        gray   = (scaled > GRAY_MAX) ? {CW{1'b1}} : scaled[CW-1:0];
        s2_in      = '0;
        s2_in.last = s1_out.last;
        s2_in.data = s1_out.data;
        if (!s1_out.hdr) begin
            case (s1_out.mode)
                MODE_GRAY_REP: s2_in.data = {gray, gray, gray};
                MODE_GRAY_LO:  s2_in.data = {{(2*CW){1'b0}}, gray};
                default:       s2_in.data = s1_out.data;
            endcase
        end
    end

    axi_stream_pipe_stage #(.W($bits(s2_t))) u_s2 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (s1_out_valid),
        .in_ready_o  (s2_in_ready),
        .in_data_i   (s2_in),
        .out_valid_o (tvalid_o),
        .out_ready_i (tready_i),
        .out_data_o  (s2_out)
    );

    assign tlast_o = s2_out.last;
    assign tdata_o = s2_out.data;

    assign frame_done_d = tvalid_o && tready_i && tlast_o;
    assign frame_done_o = frame_done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= HDR;
            cnt_q        <= '0;
            mode_q       <= MODE_GRAY_REP;
            cr_q         <= '0;
            cg_q         <= '0;
            cb_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            cr_q         <= cr_d;
            cg_q         <= cg_d;
            cb_q         <= cb_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_axi_stream_gray_conv.sv
module tb_axi_stream_gray_conv;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  mode_i = 2'd0;
    logic [7:0]  coef_r_i = 8'd76, coef_g_i = 8'd151, coef_b_i = 8'd28;
    logic        tvalid_i = 1'b0, tlast_i = 1'b0;
    logic [23:0] tdata_i = '0;
    logic        tready_o;
    logic        tvalid_o, tlast_o, frame_done_o;
    logic        tready_i = 1'b1;
    logic [23:0] tdata_o;

    axi_stream_gray_conv #(.CW(8), .HDR_WORDS(2), .COEF_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i),
        .coef_r_i(coef_r_i), .coef_g_i(coef_g_i), .coef_b_i(coef_b_i),
        .tvalid_i(tvalid_i), .tready_o(tready_o), .tlast_i(tlast_i), .tdata_i(tdata_i),
        .tvalid_o(tvalid_o), .tready_i(tready_i), .tlast_o(tlast_o), .tdata_o(tdata_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [23:0] d;
        logic        l;
        int          c;
        bit          lat;
    } exp_t;
    exp_t q[$];
    exp_t e;
    bit   lat_chk = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // drive one beat; expected output is pushed at the moment it is accepted
    task automatic send(input logic [23:0] d, input logic l, input logic [23:0] x);
        int n = 0;
        tvalid_i = 1'b1; tdata_i = d; tlast_i = l;
        @(negedge clk_i);
        while (!tready_o && n < 50) begin @(negedge clk_i); n++; end
        if (!tready_o) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: beat %0h never accepted", d);
        end else begin
            q.push_back('{d: x, l: l, c: cyc, lat: lat_chk});
        end
        @(posedge clk_i); #1;
        tvalid_i = 1'b0;
        tdata_i  = 24'($urandom);   // idle-bus noise must be ignored
        tlast_i  = 1'($urandom);
    endtask

    // scoreboard monitor
    bit          hold_v = 1'b0, fd_exp = 1'b0;
    logic [24:0] hold_d = '0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            hold_v = 1'b0;
            fd_exp = 1'b0;
        end else begin
            chk("frame_done", {31'd0, frame_done_o}, {31'd0, fd_exp});
            if (hold_v) begin
                chk("hold_valid", {31'd0, tvalid_o}, 32'd1);
                chk("hold_data", {7'd0, tlast_o, tdata_o}, {7'd0, hold_d});
            end
            if (tvalid_o && tready_i) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_beat: got %0h want none", tdata_o);
                end else begin
                    e = q.pop_front();
                    chk("tdata", {8'd0, tdata_o}, {8'd0, e.d});
                    chk("tlast", {31'd0, tlast_o}, {31'd0, e.l});
                    if (e.lat) chk("latency", cyc - e.c, 32'd2);
                end
            end
            hold_v = tvalid_o && !tready_i;
            hold_d = {tlast_o, tdata_o};
            fd_exp = tvalid_o && tready_i && tlast_o;
        end
    end

    task automatic reset_checks();
        @(negedge clk_i);
        chk("rst_tvalid", {31'd0, tvalid_o}, 32'd0);
        chk("rst_tdata", {8'd0, tdata_o}, 32'd0);
        chk("rst_tlast", {31'd0, tlast_o}, 32'd0);
        chk("rst_fdone", {31'd0, frame_done_o}, 32'd0);
        chk("rst_tready", {31'd0, tready_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("tready_after_rst", {31'd0, tready_o}, 32'd1);
        @(posedge clk_i); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        reset_checks();

        // basic frame, mode 0
        mode_i = 2'd0;
        send(24'h000280, 1'b0, 24'h000280);
        send(24'h0001E0, 1'b0, 24'h0001E0);
        send(24'h0000FF, 1'b1, 24'h4C4C4C);

        // mode 1: gray in low lane, rounding cases
        mode_i = 2'd1;
        send(24'h000280, 1'b0, 24'h000280);
        send(24'h0001E0, 1'b0, 24'h0001E0);
        send(24'hFFFFFF, 1'b0, 24'h0000FE);
        send(24'h00FF00, 1'b0, 24'h000096);
        send(24'hFF0000, 1'b0, 24'h00001C);
        send(24'hFFFFFF, 1'b1, 24'h0000FE);

        // saturation
        mode_i = 2'd0; coef_r_i = 8'd200; coef_g_i = 8'd200; coef_b_i = 8'd200;
        send(24'h000010, 1'b0, 24'h000010);
        send(24'h000020, 1'b0, 24'h000020);
        send(24'hFFFFFF, 1'b0, 24'hFFFFFF);
        send(24'h010101, 1'b1, 24'h020202);

        // bypass, and reserved mode 3
        coef_r_i = 8'd76; coef_g_i = 8'd151; coef_b_i = 8'd28;
        mode_i = 2'd2;
        send(24'h000280, 1'b0, 24'h000280);
        send(24'h0001E0, 1'b0, 24'h0001E0);
        send(24'h123456, 1'b1, 24'h123456);
        mode_i = 2'd3;
        send(24'h000280, 1'b0, 24'h000280);
        send(24'h0001E0, 1'b0, 24'h0001E0);
        send(24'hABCDEF, 1'b1, 24'hABCDEF);

        // backpressure mid-frame
        mode_i = 2'd0;
        lat_chk = 1'b0;
        fork
            begin
                send(24'h000280, 1'b0, 24'h000280);
                send(24'h0001E0, 1'b0, 24'h0001E0);
                send(24'h0000FF, 1'b0, 24'h4C4C4C);
                send(24'h00FF00, 1'b0, 24'h969696);
                send(24'hFF0000, 1'b0, 24'h1C1C1C);
                send(24'h808080, 1'b1, 24'h808080);
            end
            begin
                repeat (3) @(posedge clk_i);
                #1 tready_i = 1'b0;
                repeat (3) @(posedge clk_i);
                #1 tready_i = 1'b1;
            end
        join
        lat_chk = 1'b1;

        // mode/coef change mid-frame is ignored until next frame
        mode_i = 2'd0;
        send(24'h000280, 1'b0, 24'h000280);
        mode_i = 2'd2; coef_r_i = 8'd0;
        send(24'h0001E0, 1'b0, 24'h0001E0);
        send(24'h0000FF, 1'b1, 24'h4C4C4C);
        coef_r_i = 8'd76;

        // aborted frame: header beat with tlast, then a clean frame
        mode_i = 2'd0;
        send(24'h111111, 1'b1, 24'h111111);
        send(24'h000280, 1'b0, 24'h000280);
        send(24'h0001E0, 1'b0, 24'h0001E0);
        send(24'h0000FF, 1'b1, 24'h4C4C4C);

        // reset mid-frame with beats in flight
        repeat (4) @(posedge clk_i);
        #1;
        mode_i = 2'd1;
        lat_chk = 1'b0;
        tready_i = 1'b0;
        send(24'h000280, 1'b0, 24'h000280);
        send(24'h0001E0, 1'b0, 24'h0001E0);
        rst_i = 1'b1;
        q.delete();
        tready_i = 1'b1;
        reset_checks();
        mode_i = 2'd0;
        send(24'h0000FF, 1'b0, 24'h0000FF);   // must be treated as header 0
        send(24'h0001E0, 1'b0, 24'h0001E0);
        send(24'h0000FF, 1'b1, 24'h4C4C4C);

        begin
            int n = 0;
            while (q.size() != 0 && n < 200) begin @(negedge clk_i); n++; end
            chk("drain_left", q.size(), 32'd0);
        end
        repeat (3) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
